// File: rtl/pio_tx_osr.sv
// pio_tx_osr: PIO transmit data path. A bus-written TX FIFO feeds the output
// shift register (OSR) that the state machine drains with PULL and OUT, with
// optional autopull refill, stall indication and sticky over/stall status.
// Ports:
//   clk, reset (async, active-high), sm_restart (sync OSR clear)
//   tx_wr/tx_wdata            bus write into the FIFO
//   tx_full/tx_empty/tx_level FIFO status; txover/txstall sticky flags (+ _clr)
//   shift_right/autopull/pull_thresh/out_bits  shift configuration
//   pull_req/pull_block/pull_ifempty/x_val -> pull_done
//   out_req -> out_data/out_valid
//   stall (combinational), osr_count, osre
// Optional: define PIO_TX_FJOIN_EN to add fjoin_tx, which doubles the FIFO
// depth by borrowing the RX storage; toggling it flushes the FIFO.
module pio_tx_osr #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sm_restart,
`ifdef PIO_TX_FJOIN_EN
  input  logic                      fjoin_tx,
`endif
  input  logic                      tx_wr,
  input  logic [DATA_W-1:0]         tx_wdata,
  output logic                      tx_full,
  output logic                      tx_empty,
  output logic [3:0]                tx_level,
  output logic                      txover,
  input  logic                      txover_clr,
  output logic                      txstall,
  input  logic                      txstall_clr,
  input  logic                      shift_right,
  input  logic                      autopull,
  input  logic [$clog2(DATA_W)-1:0] pull_thresh,
  input  logic [DATA_W-1:0]         x_val,
  input  logic                      pull_req,
  input  logic                      pull_block,
  input  logic                      pull_ifempty,
  output logic                      pull_done,
  input  logic                      out_req,
  input  logic [$clog2(DATA_W)-1:0] out_bits,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      stall,
  output logic [$clog2(DATA_W):0]   osr_count,
  output logic                      osre
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned LVL_W = 4;
`ifdef PIO_TX_FJOIN_EN
  localparam int unsigned MEM_DEPTH = 2 * DEPTH;
`else
  localparam int unsigned MEM_DEPTH = DEPTH;
`endif
  localparam int unsigned PTR_W = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] osr_q, osr_d;
  logic [CNT_W-1:0]  osr_count_q, osr_count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              pull_done_q, pull_done_d;
  logic              txover_q, txover_d;
  logic              txstall_q, txstall_d;

  logic              push_c, pop_c, stall_c, flush_c;
  logic              full_c, avail_c, osre_c;
  logic [PTR_W-1:0]  ptr_mask_c;
  logic [LVL_W-1:0]  eff_depth_c;
  logic [CNT_W-1:0]  thresh_c, n_c;
  logic [SUM_W-1:0]  sum_c;
  logic [DATA_W-1:0] head_c;

  // Effective FIFO geometry; a join-mode change discards the FIFO contents.
`ifdef PIO_TX_FJOIN_EN
  logic fjoin_q;
  assign flush_c     = fjoin_tx ^ fjoin_q;
  assign ptr_mask_c  = fjoin_q ? PTR_W'(MEM_DEPTH - 1) : PTR_W'(DEPTH - 1);
  assign eff_depth_c = fjoin_q ? LVL_W'(MEM_DEPTH) : LVL_W'(DEPTH);
`else
  assign flush_c     = 1'b0;
  assign ptr_mask_c  = PTR_W'(DEPTH - 1);
  assign eff_depth_c = LVL_W'(DEPTH);
`endif

  // A zero threshold or bit count encodes a full word.
  assign thresh_c = (pull_thresh == '0) ? CNT_W'(DATA_W) : CNT_W'(pull_thresh);
  assign n_c      = (out_bits == '0) ? CNT_W'(DATA_W) : CNT_W'(out_bits);
  assign osre_c   = (osr_count_q >= thresh_c);
  assign full_c   = (level_q == eff_depth_c);
  assign avail_c  = (level_q != '0) && !flush_c;
  assign head_c   = mem_q[rd_ptr_q];
  assign sum_c    = SUM_W'(osr_count_q) + SUM_W'(n_c);

  // Next-state: sm_restart > PULL > OUT > background autopull; one pop max.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    osr_d       = osr_q;
    osr_count_d = osr_count_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    pull_done_d = 1'b0;
    txover_d    = txover_q & ~txover_clr;
    txstall_d   = txstall_q & ~txstall_clr;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    stall_c     = 1'b0;

    if (tx_wr) begin
      if (full_c) txover_d = 1'b1;
      else if (!flush_c) push_c = 1'b1;
    end

    if (sm_restart) begin
      osr_d       = '0;
      osr_count_d = CNT_W'(DATA_W);
    end else if (pull_req) begin
      if ((pull_ifempty || autopull) && !osre_c) begin
        pull_done_d = 1'b1;
      end else if (avail_c) begin
        osr_d       = head_c;
        osr_count_d = '0;
        pop_c       = 1'b1;
        pull_done_d = 1'b1;
      end else if (pull_block) begin
        stall_c   = 1'b1;
        txstall_d = 1'b1;
      end else begin
        osr_d       = x_val;
        osr_count_d = '0;
        pull_done_d = 1'b1;
      end
    end else if (out_req) begin
      if (autopull && osre_c) begin
        // Refill first; the OUT itself is retried next cycle.
        stall_c = 1'b1;
        if (avail_c) begin
          osr_d       = head_c;
          osr_count_d = '0;
          pop_c       = 1'b1;
        end else begin
          txstall_d = 1'b1;
        end
      end else begin
        if (shift_right) begin
          out_data_d = osr_q & ({DATA_W{1'b1}} >> (CNT_W'(DATA_W) - n_c));
          osr_d      = osr_q >> n_c;
        end else begin
          out_data_d = osr_q >> (CNT_W'(DATA_W) - n_c);
          osr_d      = osr_q << n_c;
        end
        osr_count_d = (sum_c > SUM_W'(DATA_W)) ? CNT_W'(DATA_W) : CNT_W'(sum_c);
        out_valid_d = 1'b1;
      end
    end else if (autopull && osre_c && avail_c) begin
      osr_d       = head_c;
      osr_count_d = '0;
      pop_c       = 1'b1;
    end

    if (push_c) wr_ptr_d = (wr_ptr_q + 1'b1) & ptr_mask_c;
    if (pop_c)  rd_ptr_d = (rd_ptr_q + 1'b1) & ptr_mask_c;
    level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // FIFO storage needs no reset: the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= tx_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      osr_q       <= '0;
      osr_count_q <= CNT_W'(DATA_W);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pull_done_q <= 1'b0;
      txover_q    <= 1'b0;
      txstall_q   <= 1'b0;
`ifdef PIO_TX_FJOIN_EN
      fjoin_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      osr_q       <= osr_d;
      osr_count_q <= osr_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      pull_done_q <= pull_done_d;
      txover_q    <= txover_d;
      txstall_q   <= txstall_d;
`ifdef PIO_TX_FJOIN_EN
      fjoin_q     <= fjoin_tx;
`endif
    end
  end

  assign tx_level  = level_q;
  assign tx_empty  = (level_q == '0);
  assign tx_full   = full_c;
  assign txover    = txover_q;
  assign txstall   = txstall_q;
  assign pull_done = pull_done_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign osr_count = osr_count_q;
  assign osre      = osre_c;
  // Stall is the only combinational status; held low while in reset.
  assign stall     = stall_c & ~reset;

endmodule

// File: tb/tb_pio_tx_osr.sv
// tb_pio_tx_osr: directed bench for pio_tx_osr with a queue-based reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_pio_tx_osr;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sm_restart = 1'b0;
  logic        tx_wr = 1'b0;
  logic [31:0] tx_wdata = '0;
  logic        tx_full, tx_empty;
  logic [3:0]  tx_level;
  logic        txover, txstall;
  logic        txover_clr = 1'b0, txstall_clr = 1'b0;
  logic        shift_right = 1'b0, autopull = 1'b0;
  logic [4:0]  pull_thresh = '0;
  logic [31:0] x_val = '0;
  logic        pull_req = 1'b0, pull_block = 1'b0, pull_ifempty = 1'b0;
  logic        pull_done;
  logic        out_req = 1'b0;
  logic [4:0]  out_bits = '0;
  logic [31:0] out_data;
  logic        out_valid, stall;
  logic [5:0]  osr_count;
  logic        osre;

  int checks = 0;
  int failures = 0;

  pio_tx_osr dut (
    .clk(clk), .reset(reset), .sm_restart(sm_restart),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
    .txover(txover), .txover_clr(txover_clr),
    .txstall(txstall), .txstall_clr(txstall_clr),
    .shift_right(shift_right), .autopull(autopull), .pull_thresh(pull_thresh),
    .x_val(x_val), .pull_req(pull_req), .pull_block(pull_block),
    .pull_ifempty(pull_ifempty), .pull_done(pull_done),
    .out_req(out_req), .out_bits(out_bits), .out_data(out_data),
    .out_valid(out_valid), .stall(stall), .osr_count(osr_count), .osre(osre)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q[$];
  logic [31:0] m_osr = '0;
  int          m_cnt = 32;
  logic [31:0] m_out_data = '0;
  bit          m_out_valid = 0, m_pull_done = 0, m_txover = 0, m_txstall = 0;

  function automatic int thr_now();
    return (pull_thresh == 0) ? 32 : int'(pull_thresh);
  endfunction

  function automatic bit exp_stall();
    bit ready;
    if (reset || sm_restart) return 1'b0;
    ready = (m_cnt >= thr_now());
    if (pull_req) begin
      if ((pull_ifempty || autopull) && !ready) return 1'b0;
      return (q.size() == 0) && pull_block;
    end
    if (out_req) return autopull && ready;
    return 1'b0;
  endfunction

  task automatic refill(input logic [31:0] v);
    m_osr = v;
    m_cnt = 0;
  endtask

  task automatic model_step();
    int n;
    bit ready, have, was_full, take;
    logic [63:0] w;
    n = (out_bits == 0) ? 32 : int'(out_bits);
    ready = (m_cnt >= thr_now());
    have = (q.size() != 0);
    was_full = (q.size() == DEPTH);
    take = 0;
    m_out_valid = 0;
    m_pull_done = 0;
    if (txover_clr) m_txover = 0;
    if (txstall_clr) m_txstall = 0;
    if (sm_restart) begin
      m_osr = '0;
      m_cnt = 32;
    end else if (pull_req) begin
      if ((pull_ifempty || autopull) && !ready) m_pull_done = 1;
      else if (have) begin refill(q[0]); take = 1; m_pull_done = 1; end
      else if (pull_block) m_txstall = 1;
      else begin refill(x_val); m_pull_done = 1; end
    end else if (out_req) begin
      if (autopull && ready) begin
        if (have) begin refill(q[0]); take = 1; end
        else m_txstall = 1;
      end else begin
        if (shift_right) begin
          w = {m_osr, 32'h0} >> n;
          m_out_data = m_osr & 32'((64'd1 << n) - 64'd1);
          m_osr = w[63:32];
        end else begin
          w = {32'h0, m_osr} << n;
          m_out_data = w[63:32];
          m_osr = w[31:0];
        end
        m_cnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
        m_out_valid = 1;
      end
    end else if (autopull && ready && have) begin
      refill(q[0]);
      take = 1;
    end
    if (take) void'(q.pop_front());
    if (tx_wr) begin
      if (was_full) m_txover = 1;
      else q.push_back(tx_wdata);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_osr = '0; m_cnt = 32; m_out_data = '0;
      m_out_valid = 0; m_pull_done = 0; m_txover = 0; m_txstall = 0;
    end else begin
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tx_level",  64'(tx_level),  64'(q.size()));
    chk("tx_empty",  64'(tx_empty),  64'(q.size() == 0));
    chk("tx_full",   64'(tx_full),   64'(q.size() == DEPTH));
    chk("txover",    64'(txover),    64'(m_txover));
    chk("txstall",   64'(txstall),   64'(m_txstall));
    chk("osr_count", 64'(osr_count), 64'(m_cnt));
    chk("osre",      64'(osre),      64'(m_cnt >= thr_now()));
    chk("out_valid", 64'(out_valid), 64'(m_out_valid));
    chk("out_data",  64'(out_data),  64'(m_out_data));
    chk("pull_done", 64'(pull_done), 64'(m_pull_done));
    chk("stall",     64'(stall),     64'(exp_stall()));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] d);
    tx_wr = 1'b1; tx_wdata = d;
    cyc();
    tx_wr = 1'b0;
  endtask

  task automatic do_out(input int bits, input bit right, output int stalls);
    bit done;
    out_bits = 5'(bits); shift_right = right; out_req = 1'b1;
    stalls = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall) stalls++;
      else done = 1;
      cyc();
    end
    out_req = 1'b0;
    if (!done) chk("out_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_pull(input bit blk, input bit ife, output int stalls);
    bit done;
    pull_block = blk; pull_ifempty = ife; pull_req = 1'b1;
    stalls = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (stall) stalls++;
      else done = 1;
      cyc();
    end
    pull_req = 1'b0; pull_block = 1'b0; pull_ifempty = 1'b0;
    if (!done) chk("pull_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_seq [4];
    int s;
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;

    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("rst_empty", 64'(tx_empty), 64'd1);
    chk("rst_level", 64'(tx_level), 64'd0);
    chk("rst_count", 64'(osr_count), 64'd32);
    chk("rst_osre",  64'(osre), 64'd1);

    // Fill to full, overflow, clear.
    for (int i = 0; i < 4; i++) write(exp_seq[i]);
    chk("fill_full",  64'(tx_full), 64'd1);
    chk("fill_level", 64'(tx_level), 64'd4);
    write(32'h55);
    chk("over_set",   64'(txover), 64'd1);
    chk("over_level", 64'(tx_level), 64'd4);
    txover_clr = 1'b1; cyc(); txover_clr = 1'b0;
    chk("over_clr", 64'(txover), 64'd0);

    // Drain in order; the overflowed 0x55 must not appear.
    for (int i = 0; i < 4; i++) begin
      do_pull(1'b0, 1'b0, s);
      chk("drain_done", 64'(pull_done), 64'd1);
      do_out(8, 1'b1, s);
      chk("drain_data", 64'(out_data), 64'(exp_seq[i]));
    end
    chk("drain_empty", 64'(tx_empty), 64'd1);

    // LSB-first and MSB-first OUT of 8.
    write(32'h89ABCDEF);
    do_pull(1'b1, 1'b0, s);
    chk("pull_nostall", 64'(s), 64'd0);
    do_out(8, 1'b1, s);
    chk("out_r8", 64'(out_data), 64'hEF);
    chk("out_r8_cnt", 64'(osr_count), 64'd8);
    write(32'h89ABCDEF);
    do_pull(1'b1, 1'b0, s);
    do_out(8, 1'b0, s);
    chk("out_l8", 64'(out_data), 64'h89);

    // Blocking PULL on empty FIFO stalls until a write lands.
    pull_block = 1'b1; pull_req = 1'b1;
    #1 chk("bpull_stall", 64'(stall), 64'd1);
    cyc();
    chk("bpull_txstall", 64'(txstall), 64'd1);
    tx_wr = 1'b1; tx_wdata = 32'hA5;
    cyc();
    tx_wr = 1'b0;
    #1 chk("bpull_release", 64'(stall), 64'd0);
    cyc();
    chk("bpull_done", 64'(pull_done), 64'd1);
    pull_req = 1'b0; pull_block = 1'b0;
    txstall_clr = 1'b1; cyc(); txstall_clr = 1'b0;
    chk("txstall_clr", 64'(txstall), 64'd0);
    do_out(0, 1'b1, s);
    chk("bpull_data", 64'(out_data), 64'hA5);

    // Non-blocking PULL on empty FIFO takes X.
    x_val = 32'h1234;
    do_pull(1'b0, 1'b0, s);
    chk("nbpull_stall", 64'(s), 64'd0);
    chk("nbpull_cnt", 64'(osr_count), 64'd0);
    do_out(16, 1'b1, s);
    chk("nbpull_data", 64'(out_data), 64'h1234);

    // Autopull at threshold 8.
    autopull = 1'b1; pull_thresh = 5'd8;
    write(32'hF0);
    write(32'h0F);
    do_out(8, 1'b1, s);
    chk("ap_out1", 64'(out_data), 64'hF0);
    chk("ap_stall1", 64'(s), 64'd0);
    do_out(8, 1'b1, s);
    chk("ap_out2", 64'(out_data), 64'h0F);
    chk("ap_stall2", 64'(s), 64'd1);

    // Conditional PULL no-op, then restart overriding an OUT.
    autopull = 1'b0; pull_thresh = 5'd0;
    write(32'h77);
    write(32'h66);
    do_pull(1'b0, 1'b1, s);
    chk("ifempty_done", 64'(pull_done), 64'd1);
    chk("ifempty_level", 64'(tx_level), 64'd2);
    sm_restart = 1'b1; out_req = 1'b1; out_bits = 5'd4;
    cyc();
    sm_restart = 1'b0; out_req = 1'b0;
    chk("rs_count", 64'(osr_count), 64'd32);
    chk("rs_osre", 64'(osre), 64'd1);
    chk("rs_level", 64'(tx_level), 64'd2);
    chk("rs_novalid", 64'(out_valid), 64'd0);

    // Reset asserted during a stall.
    do_pull(1'b0, 1'b0, s);
    do_pull(1'b0, 1'b0, s);
    pull_block = 1'b1; pull_req = 1'b1;
    cyc();
    chk("st_stall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    chk("mr_stall", 64'(stall), 64'd0);
    chk("mr_txstall", 64'(txstall), 64'd0);
    chk("mr_count", 64'(osr_count), 64'd32);
    chk("mr_empty", 64'(tx_empty), 64'd1);
    chk("mr_data", 64'(out_data), 64'd0);
    pull_req = 1'b0; pull_block = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    write(32'hDEADBEEF);
    do_pull(1'b0, 1'b0, s);
    do_out(4, 1'b0, s);
    chk("post_rst", 64'(out_data), 64'hD);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_tx_osr.md
Name: pio_tx_osr

Overview:
- Transmit side of the PIO data path: 4-entry TX FIFO written by the bus, plus the Output Shift Register (OSR) that the state machine drains with PULL and OUT.
- Write-to-read counterpart of the state machine's OSR consumer.
- Supplies OSR data, OSR-empty status and stall indications to the state machine.
- Sits between the PIO register block (TXF writes, FSTAT/FDEBUG) and the state machine.

Parameters:
- DATA_W, 32, width of FIFO entries and OSR
- DEPTH, 4, TX FIFO entries (power of two)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sm_restart  in  1  synchronous clear of OSR and shift count (FIFO untouched)
- tx_wr  in  1  bus write strobe into TX FIFO
- tx_wdata  in  32  bus write data
- tx_full  out  1  FIFO full
- tx_empty  out  1  FIFO empty
- tx_level  out  4  FIFO occupancy, 0..DEPTH
- txover  out  1  sticky: write attempted while full
- txover_clr  in  1  clears txover
- txstall  out  1  sticky: state machine stalled on an empty FIFO
- txstall_clr  in  1  clears txstall
- shift_right  in  1  1 = shift LSB-first, 0 = MSB-first
- autopull  in  1  enable automatic refill
- pull_thresh  in  5  refill threshold; 0 means 32
- x_val  in  32  scratch X, source for non-blocking PULL from an empty FIFO
- pull_req  in  1  PULL instruction strobe
- pull_block  in  1  1 = blocking PULL
- pull_ifempty  in  1  PULL only if OSR count >= threshold
- pull_done  out  1  pulse: PULL completed
- out_req  in  1  OUT instruction strobe
- out_bits  in  5  bit count; 0 means 32
- out_data  out  32  shifted-out bits, right-justified
- out_valid  out  1  pulse: out_data valid
- stall  out  1  PULL or OUT cannot complete this cycle
- osr_count  out  6  bits consumed, 0..32
- osre  out  1  osr_count >= threshold (threshold 0 maps to 32)

Behaviour:
- Reset values:
  - FIFO pointers 0; tx_level 0; tx_empty 1; tx_full 0.
  - osr 0; osr_count 32; osre 1.
  - out_data 0; out_valid, pull_done, stall, txover, txstall all 0.
- Status outputs are registered.
- FIFO:
  - Write accepted when not full, judged on the pre-cycle state.
  - tx_wr while full: data dropped, txover <= 1.
  - Push and pop in the same cycle: level unchanged.
  - Pointers wrap modulo DEPTH.
- Pop priority: explicit PULL > autopull. At most one pop per cycle.
- PULL (pull_req=1, evaluated on the clock edge):
  - pull_ifempty=1 and osr_count < threshold: no-op; pull_done pulses next cycle.
  - FIFO non-empty: osr <= head, osr_count <= 0, pop; pull_done pulses next cycle.
  - FIFO empty, pull_block=1: stall=1 combinationally; txstall <= 1; the state machine holds pull_req until pull_done.
  - FIFO empty, pull_block=0: osr <= x_val, osr_count <= 0, pull_done pulses.
  - With autopull=1, a PULL while osr_count < threshold is a no-op (completes, no pop).
- OUT (n = out_bits, 0 means 32):
  - shift_right=1: out_data = osr[n-1:0] zero-extended; osr <= osr >> n.
  - shift_right=0: out_data = osr[31:32-n] right-justified; osr <= osr << n.
  - osr_count <= min(osr_count + n, 32) (saturating).
  - Result registered; out_valid pulses 1 cycle after acceptance.
  - autopull=0, osr_count=32: OUT still proceeds and shifts zeros.
  - autopull=1 and osre=1 at OUT time: if the FIFO is non-empty, refill (osr <= head, count 0, pop) this cycle and stall=1; the OUT executes next cycle. If the FIFO is empty, stall=1 and txstall <= 1.
- Background autopull: autopull=1, osre=1, no pull_req/out_req, FIFO non-empty -> refill that cycle.
- sm_restart: osr 0, osr_count 32, no pop; overrides a simultaneous PULL or OUT.
- Sticky flags: set wins over clear in the same cycle.
- Reset mid-operation: everything returns to reset values; FIFO contents are discarded.

Optional Feature:
- Macro: PIO_TX_FJOIN_EN.
- When defined: adds input fjoin_tx (1 bit); when high, the FIFO depth becomes 2*DEPTH (8) by borrowing the RX storage; tx_level widens to reach 8.
- Toggling fjoin_tx flushes the FIFO.
- When undefined: no port; depth fixed at DEPTH.

Test Plan:
- Write 0x11,0x22,0x33,0x44 -> tx_full=1, tx_level=4. Fifth write 0x55 -> dropped, txover=1. txover_clr -> txover=0.
- tx_wdata=0x89ABCDEF, PULL blocking, OUT 8 with shift_right=1 -> out_data=0xEF, osr_count=8. OUT 8 with shift_right=0 on a fresh PULL -> out_data=0x89.
- PULL blocking on empty FIFO -> stall=1, txstall=1. Write 0xA5 -> pull_done next cycle, osr=0xA5.
- PULL non-blocking on empty FIFO, x_val=0x1234 -> osr=0x1234, osr_count=0, no stall.
- autopull=1, pull_thresh=8, FIFO holds 0xF0,0x0F, OUT 8 x2 (shift_right=1) -> out_data 0xF0 then 0x0F. The second OUT stalls exactly 1 cycle for the refill.
- Mid-stream assert sm_restart -> osr_count=32, osre=1, tx_level unchanged. Assert reset during a stall -> all outputs at reset values.
